// File: rtl/uart_rx_deserializer_if.sv
// rtl/uart_rx_deserializer_if.sv - serial line, parity config and received-word bundle for the UART RX deserializer
interface uart_rx_deserializer_if #(
  parameter int DATA_W = 8
);
  logic              rx_in;
  logic              par_en;
  logic              par_typ;
  logic [DATA_W-1:0] p_data;
  logic              data_valid;
  logic              par_err;
  logic              stp_err;
  logic              busy;

  // Pad/driver side: drives the line and frame configuration
  modport master (
    output rx_in, par_en, par_typ,
    input  p_data, data_valid, par_err, stp_err, busy
  );

  // Deserializer side
  modport slave (
    input  rx_in, par_en, par_typ,
    output p_data, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - oversampling UART receiver; UART_RX_MAJORITY_EN selects 2-of-3 bit voting
module uart_rx_deserializer #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 8
) (
  input logic                  clk,
  input logic                  rst,
  uart_rx_deserializer_if.slave rx_if
);
  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W + 3);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [EW-1:0] DEC_CNT = EW'(OVERSAMPLE / 2 + 1);
`else
  localparam logic [EW-1:0] DEC_CNT = EW'(OVERSAMPLE / 2);
`endif
  localparam logic [EW-1:0] LAST_CNT  = EW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] p_data_q, p_data_d;
  logic              par_en_q, par_en_d;
  logic              par_typ_q, par_typ_d;
  logic              par_bad_q, par_bad_d;
  logic              stp_bad_q, stp_bad_d;
  logic              frame_end_q, frame_end_d;
  logic              data_valid_q, data_valid_d;
  logic              par_err_q, par_err_d;
  logic              stp_err_q, stp_err_d;
  logic              busy_q, busy_d;
  logic              bit_val;
  logic              decide;
`ifdef UART_RX_MAJORITY_EN
  logic              samp0_q, samp0_d;
  logic              samp1_q, samp1_d;
`endif

  // Next-state, sampling and frame-end pulse computation
  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_bad_d    = par_bad_q;
    stp_bad_d    = stp_bad_q;
    frame_end_d  = 1'b0;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    decide       = (edge_cnt_q == DEC_CNT);
`ifdef UART_RX_MAJORITY_EN
    samp0_d = (edge_cnt_q == EW'(OVERSAMPLE / 2 - 1)) ? rx_if.rx_in : samp0_q;
    samp1_d = (edge_cnt_q == EW'(OVERSAMPLE / 2))     ? rx_if.rx_in : samp1_q;
    bit_val = (samp0_q & samp1_q) | (samp0_q & rx_if.rx_in) | (samp1_q & rx_if.rx_in);
`else
    bit_val = rx_if.rx_in;
`endif

    // Pulses belong to the frame that ended last cycle; independent of a frame starting now
    if (frame_end_q) begin
      data_valid_d = ~par_bad_q & ~stp_bad_q;
      par_err_d    = par_bad_q;
      stp_err_d    = stp_bad_q;
      if (~par_bad_q & ~stp_bad_q) p_data_d = shift_q;
    end

    if (state_q != IDLE) begin
      if (edge_cnt_q == LAST_CNT) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + BW'(1);
      end else begin
        edge_cnt_d = edge_cnt_q + EW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (!rx_if.rx_in) begin
          state_d    = START;
          edge_cnt_d = EW'(1);
          bit_cnt_d  = '0;
          par_en_d   = rx_if.par_en;
          par_typ_d  = rx_if.par_typ;
          par_bad_d  = 1'b0;
          stp_bad_d  = 1'b0;
        end
      end
      START: begin
        if (decide) begin
          if (bit_val) begin
            state_d    = IDLE;
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (decide) begin
          shift_d = {bit_val, shift_q[DATA_W-1:1]};
          if (bit_cnt_q == LAST_DATA) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (decide) begin
          par_bad_d = (^{shift_q, bit_val}) != par_typ_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          stp_bad_d   = ~bit_val;
          frame_end_d = 1'b1;
          state_d     = IDLE;
          edge_cnt_d  = '0;
          bit_cnt_d   = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Receiver FSM, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      p_data_q     <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      stp_bad_q    <= 1'b0;
      frame_end_q  <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      samp0_q      <= 1'b1;
      samp1_q      <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_bad_q    <= par_bad_d;
      stp_bad_q    <= stp_bad_d;
      frame_end_q  <= frame_end_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      busy_q       <= busy_d;
`ifdef UART_RX_MAJORITY_EN
      samp0_q      <= samp0_d;
      samp1_q      <= samp1_d;
`endif
    end
  end

  assign rx_if.p_data     = p_data_q;
  assign rx_if.data_valid = data_valid_q;
  assign rx_if.par_err    = par_err_q;
  assign rx_if.stp_err    = stp_err_q;
  assign rx_if.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - scoreboard bench for the UART RX deserializer
module tb_uart_rx_deserializer;
`ifdef UART_RX_MAJORITY_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif
  localparam logic [2:0] K_DV = 3'b001;
  localparam logic [2:0] K_PE = 3'b010;
  localparam logic [2:0] K_SE = 3'b100;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  uart_rx_deserializer_if #(.DATA_W(8)) rx_if ();

  uart_rx_deserializer #(.DATA_W(8), .OVERSAMPLE(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (rx_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt++;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc_cnt);
  endtask

  // Monitor: every output pulse must match the oldest expected frame result
  always @(negedge clk) begin
    if (!rst && (rx_if.data_valid || rx_if.par_err || rx_if.stp_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {rx_if.stp_err, rx_if.par_err, rx_if.data_valid}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_cycle", cyc_cnt, mon_e.cyc);
        check("pulse_kind", {rx_if.stp_err, rx_if.par_err, rx_if.data_valid}, mon_e.kind);
        check("p_data", rx_if.p_data, mon_e.data);
      end
    end
  end

  task automatic drive_seg(input logic b, input int n);
    rx_if.rx_in = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    if (glitch) begin
      drive_seg(b, 4);
      drive_seg(~b, 1);
      drive_seg(b, 3);
    end else begin
      drive_seg(b, 8);
    end
  endtask

  // Pushes the expected result, then serialises one frame; config is inverted after the start bit
  task automatic send_frame(input logic [7:0] data, input bit has_par, input bit typ,
                            input bit par_bit, input bit stop_bit, input int glitch_bit,
                            input logic [2:0] kind, input logic [7:0] exp_data);
    exp_t e;
    e.cyc  = cyc_cnt + 1 + 77 + (has_par ? 8 : 0) + DLY;
    e.kind = kind;
    e.data = exp_data;
    exp_q.push_back(e);
    rx_if.par_en  = has_par;
    rx_if.par_typ = typ;
    drive_bit(1'b0, 1'b0);
    rx_if.par_en  = ~has_par;
    rx_if.par_typ = ~typ;
    for (int i = 0; i < 8; i++) drive_bit(data[i], glitch_bit == i);
    if (has_par) drive_bit(par_bit, 1'b0);
    drive_bit(stop_bit, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rx_if.rx_in   = 1'b1;
    rx_if.par_en  = 1'b0;
    rx_if.par_typ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {rx_if.stp_err, rx_if.par_err, rx_if.data_valid, rx_if.busy}, 0);
    check("reset_p_data", rx_if.p_data, 0);
    rst = 1'b0;
    drive_seg(1'b1, 5);

    send_frame(8'hA5, 0, 0, 0, 1, -1, K_DV, 8'hA5);
    drive_seg(1'b1, 10);
    send_frame(8'h3C, 1, 0, 1, 1, -1, K_PE, 8'hA5);
    drive_seg(1'b1, 10);
    send_frame(8'h3C, 1, 0, 0, 1, -1, K_DV, 8'h3C);
    drive_seg(1'b1, 10);
    send_frame(8'h07, 1, 1, 0, 1, -1, K_DV, 8'h07);
    drive_seg(1'b1, 10);
    send_frame(8'h07, 1, 0, 0, 0, -1, K_PE | K_SE, 8'h07);
    drive_seg(1'b1, 20);
    send_frame(8'hA5, 0, 0, 0, 1, -1, K_DV, 8'hA5);
    drive_seg(1'b1, 10);
    send_frame(8'h55, 0, 0, 0, 0, -1, K_SE, 8'hA5);
    drive_seg(1'b1, 20);

    // Short low glitch must not start a frame
    drive_seg(1'b0, 2);
    drive_seg(1'b1, 20);
    send_frame(8'h81, 0, 0, 0, 1, -1, K_DV, 8'h81);
    drive_seg(1'b1, 10);

    // Back-to-back frames with a single stop bit
    send_frame(8'h01, 0, 0, 0, 1, -1, K_DV, 8'h01);
    send_frame(8'hFE, 0, 0, 0, 1, -1, K_DV, 8'hFE);
    drive_seg(1'b1, 10);

    // Reset 30 cycles into a frame
    drive_seg(1'b0, 8);
    drive_seg(1'b1, 8);
    drive_seg(1'b0, 8);
    drive_seg(1'b1, 6);
    check("busy_mid_frame", rx_if.busy, 1);
    rst = 1'b1;
    #1;
    check("abort_outputs", {rx_if.stp_err, rx_if.par_err, rx_if.data_valid, rx_if.busy}, 0);
    check("abort_p_data", rx_if.p_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_seg(1'b1, 10);
    send_frame(8'h7E, 0, 0, 0, 1, -1, K_DV, 8'h7E);
    drive_seg(1'b1, 10);

    // One-cycle glitch on data bit 3 at its sample point
`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h5A, 0, 0, 0, 1, 3, K_DV, 8'h5A);
`else
    send_frame(8'h5A, 0, 0, 0, 1, 3, K_DV, 8'h52);
`endif
    drive_seg(1'b1, 100);
    check("missing_pulses", exp_q.size(), 0);
    check("idle_busy", rx_if.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
